// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: pipeline request/response channel plus the data-memory port.
// The slave modport is the unit's view; master is the view of the pipeline and memory around it.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data_in;
  logic [1:0]            mem_write;
  logic [1:0]            mem_data;
  logic [31:0]           mem_data_out;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_data_in, mem_write, mem_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_data_in, mem_write, mem_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with RV32 load extension. Defining MEM_ACCESS_MISALIGN_SPLIT_EN
// splits misaligned half/word accesses into byte sequences; otherwise they are rejected.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StAccess, StByteSeq, StResp} state_e;

  state_e                state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  logic [1:0]            idx_q, idx_d;
`endif

  logic [1:0]  req_size;
  logic        req_legal;
  logic        req_misal;
  logic [31:0] ext_rdata;

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    req_size = bus_io.req_funct3[1:0];
    if (bus_io.req_store) begin
      req_legal = ~bus_io.req_funct3[2] && (req_size != 2'b11);
    end else begin
      req_legal = (req_size != 2'b11) && !(bus_io.req_funct3[2] && (req_size == 2'b10));
    end
    case (req_size)
      2'b01:   req_misal = bus_io.req_addr[0];
      2'b10:   req_misal = |bus_io.req_addr[1:0];
      default: req_misal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ext_rdata = {{24{~funct3_q[2] & rdata_q[7]}}, rdata_q[7:0]};
      2'b01:   ext_rdata = {{16{~funct3_q[2] & rdata_q[15]}}, rdata_q[15:0]};
      default: ext_rdata = rdata_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    idx_d    = idx_q;
`endif
    bus_io.req_ready   = 1'b0;
    bus_io.resp_valid  = 1'b0;
    bus_io.resp_rdata  = 32'h0;
    bus_io.resp_error  = 1'b0;
    bus_io.mem_address = '0;
    bus_io.mem_data_in = 32'h0;
    bus_io.mem_write   = 2'b00;
    bus_io.mem_data    = 2'b00;

    unique case (state_q)
      StIdle: begin
        bus_io.req_ready = 1'b1;
        if (bus_io.req_valid) begin
          store_d  = bus_io.req_store;
          funct3_d = bus_io.req_funct3;
          addr_d   = bus_io.req_addr;
          wdata_d  = bus_io.req_wdata;
          rdata_d  = 32'h0;
          error_d  = 1'b0;
          if (!req_legal) begin
            error_d = 1'b1;
            state_d = StResp;
          end else if (req_misal) begin
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            idx_d   = 2'd0;
            state_d = StByteSeq;
`else
            error_d = 1'b1;
            state_d = StResp;
`endif
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        bus_io.mem_address = addr_q;
        bus_io.mem_data    = funct3_q[1:0];
        if (store_q) begin
          bus_io.mem_write   = funct3_q[1:0] + 2'd1;
          bus_io.mem_data_in = wdata_q;
        end else begin
          rdata_d = bus_io.mem_data_out;
        end
        state_d = StResp;
      end
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
      StByteSeq: begin
        bus_io.mem_address = addr_q + ADDR_WIDTH'(idx_q);
        if (store_q) begin
          bus_io.mem_write   = 2'b01;
          bus_io.mem_data_in = {24'h0, wdata_q[{idx_q, 3'b000} +: 8]};
        end else begin
          rdata_d[{idx_q, 3'b000} +: 8] = bus_io.mem_data_out[7:0];
        end
        if (idx_q == (funct3_q[1] ? 2'd3 : 2'd1)) begin
          state_d = StResp;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
`endif
      StResp: begin
        bus_io.resp_valid = 1'b1;
        bus_io.resp_error = error_q;
        bus_io.resp_rdata = (store_q || error_q) ? 32'h0 : ext_rdata;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      error_q  <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
      idx_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
      idx_q    <= idx_d;
`endif
    end
  end

endmodule
